// File: rtl/fp_operand_out.sv
// fp_operand_out: Avalon-MM write-side slave that stages FP operands and an
// opcode from the CPU and issues them to the external FP datapath over a
// valid/ready handshake. Exposes busy/done/error status, a wrapping count of
// accepted commands and a done interrupt.
module fp_operand_out #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [OP_W-1:0]   out_op,
    output logic              out_valid,
    input  logic              out_ready
);

    // register map
    localparam logic [1:0] ADDR_A      = 2'd0;
    localparam logic [1:0] ADDR_B      = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL / STATUS bit positions
    localparam int GO_BIT     = 31;
    localparam int IRQ_EN_BIT = 8;
    localparam int BUSY_BIT   = 0;
    localparam int DONE_BIT   = 1;
    localparam int ERR_BIT    = 2;
    localparam int CNT_LSB    = 16;

    // command presented to the FP datapath
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } fp_cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state;
    fp_cmd_t           cmd_q;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic              irq_en_q;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              wr;
    logic              wr_a;
    logic              wr_b;
    logic              wr_ctrl;
    logic              wr_status;
    logic              go;
    logic              busy;
    logic              accept;
    logic              done_clr;
    logic              err_clr;
    logic              err_set;
    logic [DATA_W-1:0] rd_mux;

    assign wr        = chipselect & ~write_n;
    assign wr_a      = wr & (address == ADDR_A);
    assign wr_b      = wr & (address == ADDR_B);
    assign wr_ctrl   = wr & (address == ADDR_CTRL);
    assign wr_status = wr & (address == ADDR_STATUS);

    // go is a pulse carried by the CTRL write itself; it is never stored
    assign go        = wr_ctrl & writedata[GO_BIT];
    assign busy      = (state == ISSUE);
    assign accept    = busy & out_valid & out_ready;

    // a go that arrives while a command is outstanding is dropped and flagged,
    // even on the very cycle the outstanding command is being accepted
    assign err_set   = go & busy;
    assign done_clr  = wr_status & writedata[DONE_BIT];
    assign err_clr   = wr_status & writedata[ERR_BIT];

    assign out_a     = cmd_q.a;
    assign out_b     = cmd_q.b;
    assign out_op    = cmd_q.op;
    assign irq       = done_q & irq_en_q;

    // issue FSM: capture the command on go, hold it stable until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // out_ready is meaningless here and deliberately ignored
                    if (go) begin
                        cmd_q.a   <= a_q;
                        cmd_q.b   <= b_q;
                        cmd_q.op  <= writedata[OP_W-1:0];
                        out_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // staging writes land in a_q/b_q/op_q only; cmd_q stays put
                    if (accept) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // CPU-visible staging registers and CTRL fields
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            irq_en_q <= 1'b0;
        end else begin
            if (wr_a)
                a_q <= writedata;
            if (wr_b)
                b_q <= writedata;
            if (wr_ctrl) begin
                op_q     <= writedata[OP_W-1:0];
                irq_en_q <= writedata[IRQ_EN_BIT];
            end
        end
    end

    // sticky done/err with write-one-to-clear; a set on the same edge wins
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept)
                done_q <= 1'b1;
            else if (done_clr)
                done_q <= 1'b0;

            if (err_set)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end

    // accepted-command counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= cnt_q + 1'b1;
    end

    // read mux over the current register contents
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_A:    rd_mux = a_q;
            ADDR_B:    rd_mux = b_q;
            ADDR_CTRL: begin
                rd_mux[OP_W-1:0]   = op_q;
                rd_mux[IRQ_EN_BIT] = irq_en_q;
            end
            ADDR_STATUS: begin
                rd_mux[BUSY_BIT]          = busy;
                rd_mux[DONE_BIT]          = done_q;
                rd_mux[ERR_BIT]           = err_q;
                rd_mux[CNT_LSB +: CNT_W]  = cnt_q;
            end
            default:   rd_mux = '0;
        endcase
    end

    // readdata follows address every cycle, independent of chipselect
    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_fp_operand_out.sv
// tb_fp_operand_out: directed + randomized bench for fp_operand_out.
// A transaction-level model predicts register reads and issued commands;
// expectations are queued and a negedge monitor pops and compares them.
module tb_fp_operand_out;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;
    localparam int CNT_W  = 8;   // small counter so wrap-around is reachable

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              irq;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [OP_W-1:0]   out_op;
    logic              out_valid;
    logic              out_ready;

    fp_operand_out #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } cmd_t;

    int          checks = 0;
    int          errors = 0;
    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd[$];
    bit          rd_pend = 1'b0;

    // reference model state (what software would see)
    logic [31:0] m_a, m_b;
    logic [2:0]  m_op;
    bit          m_irqen, m_busy, m_done, m_err;
    int          m_cnt;
    cmd_t        m_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] ad);
        case (ad)
            2'd0: return m_a;
            2'd1: return m_b;
            2'd2: return {23'b0, m_irqen, 5'b0, m_op};
            default: return (32'(m_cnt) << 16) | (32'(m_err) << 2) |
                            (32'(m_done) << 1) | 32'(m_busy);
        endcase
    endfunction

    // One bus cycle: drive inputs, predict the edge, then check after it.
    task automatic cyc(input bit cs, input bit wn, input logic [1:0] ad,
                       input logic [31:0] wd, input bit rdy, input bit rst = 1'b0,
                       input bit use_lit = 1'b0, input logic [31:0] lit = 32'h0);
        bit wr, go, acc, busy0;
        chipselect = cs; write_n = wn; address = ad; writedata = wd;
        out_ready = rdy; reset = rst;
        wr = cs && !wn;
        if (cs && wn && !rst)
            exp_rd.push_back(use_lit ? lit : m_read(ad));
        if (rst) begin
            if (m_busy) void'(exp_cmd.pop_back());
            m_a = 0; m_b = 0; m_op = 0; m_irqen = 0;
            m_busy = 0; m_done = 0; m_err = 0; m_cnt = 0; m_cur = '{0, 0, 0};
        end else begin
            busy0 = m_busy;
            acc   = busy0 && rdy;
            go    = wr && ad == 2'd2 && wd[31];
            if (wr && ad == 2'd3 && wd[1]) m_done = 0;
            if (wr && ad == 2'd3 && wd[2]) m_err = 0;
            if (acc) begin
                m_busy = 0; m_done = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (go) begin
                if (busy0) m_err = 1;
                else begin
                    m_cur = '{m_a, m_b, wd[2:0]};
                    exp_cmd.push_back(m_cur);
                    m_busy = 1;
                end
            end
            if (wr && ad == 2'd0) m_a = wd;
            if (wr && ad == 2'd1) m_b = wd;
            if (wr && ad == 2'd2) begin m_op = wd[2:0]; m_irqen = wd[8]; end
        end
        @(posedge clk); #1;
        chk("out_valid", 32'(out_valid), 32'(m_busy));
        chk("irq", 32'(irq), 32'(m_done & m_irqen));
        if (m_busy) begin
            chk("hold_a", out_a, m_cur.a);
            chk("hold_b", out_b, m_cur.b);
            chk("hold_op", 32'(out_op), 32'(m_cur.op));
        end
    endtask

    task automatic wr_reg(input logic [1:0] ad, input logic [31:0] wd, input bit rdy = 1'b0);
        cyc(1'b1, 1'b0, ad, wd, rdy);
    endtask

    task automatic rd_reg(input logic [1:0] ad, input bit rdy = 1'b0);
        cyc(1'b1, 1'b1, ad, 32'h0, rdy);
    endtask

    task automatic rd_lit(input logic [1:0] ad, input logic [31:0] val);
        cyc(1'b1, 1'b1, ad, 32'h0, 1'b0, 1'b0, 1'b1, val);
    endtask

    task automatic idle(input int n, input bit rdy = 1'b0);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'd0, 32'h0, rdy);
    endtask

    // read responses are due one cycle after a read is presented
    always @(posedge clk) rd_pend <= chipselect && write_n && !reset;

    // monitor: pop and compare whenever the DUT presents a read or a handshake
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
            else chk("readdata", readdata, exp_rd.pop_front());
        end
        if (out_valid && out_ready && !reset) begin
            if (exp_cmd.size() == 0) chk("cmd_underflow", 32'd1, 32'd0);
            else begin
                chk("cmd_a", out_a, exp_cmd[0].a);
                chk("cmd_b", out_b, exp_cmd[0].b);
                chk("cmd_op", 32'(out_op), 32'(exp_cmd[0].op));
                void'(exp_cmd.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
        writedata = 32'h0; out_ready = 1'b0;

        // T1 reset
        cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
        chk("reset_readdata", readdata, 32'h0);
        rd_lit(2'd3, 32'h0);

        // T2 basic issue
        wr_reg(2'd0, 32'h3F80_0000);
        wr_reg(2'd1, 32'h4000_0000);
        wr_reg(2'd2, 32'h8000_0002, 1'b1);
        idle(1, 1'b1);
        rd_lit(2'd3, 32'h0001_0002);
        rd_lit(2'd2, 32'h0000_0002);

        // T3 backpressure, staging write mid-wait must not reach out_a
        wr_reg(2'd0, 32'h1111_1111);
        wr_reg(2'd2, 32'h8000_0003);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) wr_reg(2'd0, 32'hDEAD_BEEF);
            else rd_reg(2'd3);
        end
        idle(1, 1'b1);
        rd_lit(2'd3, 32'h0002_0002);
        rd_lit(2'd0, 32'hDEAD_BEEF);

        // T4 go while busy
        wr_reg(2'd3, 32'h2);
        wr_reg(2'd2, 32'h8000_0001);
        wr_reg(2'd2, 32'h8000_0004);
        rd_lit(2'd3, 32'h0002_0005);
        wr_reg(2'd3, 32'h4);
        rd_lit(2'd3, 32'h0002_0001);
        idle(1, 1'b1);
        rd_lit(2'd3, 32'h0003_0002);

        // T5 irq, W1C, and done-set colliding with W1C
        wr_reg(2'd2, 32'h8000_0101, 1'b1);
        idle(1, 1'b1);
        chk("irq_set", 32'(irq), 32'd1);
        wr_reg(2'd3, 32'h2);
        chk("irq_clr", 32'(irq), 32'd0);
        wr_reg(2'd2, 32'h8000_0101);
        wr_reg(2'd3, 32'h2, 1'b1);
        chk("irq_set_wins", 32'(irq), 32'd1);
        rd_lit(2'd3, 32'h0005_0002);

        // T6 counter wrap, then reset during ISSUE
        while (m_cnt != (1 << CNT_W) - 1) begin
            wr_reg(2'd2, 32'h8000_0005, 1'b1);
            idle(1, 1'b1);
        end
        wr_reg(2'd2, 32'h8000_0006);
        idle(2, 1'b0);
        idle(1, 1'b1);
        rd_lit(2'd3, 32'h0000_0002);
        wr_reg(2'd2, 32'h8000_0007);
        idle(1, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b1);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        rd_lit(2'd3, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            wd[31] = ($urandom_range(0, 3) == 0);
            cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                2'($urandom_range(0, 3)), wd, $urandom_range(0, 1),
                ($urandom_range(0, 199) == 0));
        end

        // drain outstanding work and make sure nothing was left unmatched
        idle(4, 1'b1);
        chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
